// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        REQ_IF,
        REQ_D
    } req_id_e;

    typedef struct packed {
        logic                  we;
        logic [BE_W_DEF-1:0]   be;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational requester picker: data over fetch by default, or round-robin
// on ties when MEM_ARB_RR_EN is defined.
module arb_grant_sel
    import mem_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    d_req,
`ifdef MEM_ARB_RR_EN
    input  req_id_e last_grant,
`endif
    output req_id_e grant
);

`ifdef MEM_ARB_RR_EN
    // On a tie, serve whichever requester was not served last.
    always_comb begin
        grant = REQ_IF;
        if (if_req && d_req) begin
            grant = (last_grant == REQ_D) ? REQ_IF : REQ_D;
        end else if (d_req) begin
            grant = REQ_D;
        end
    end
`else
    always_comb begin
        grant = REQ_IF;
        if (d_req) begin
            grant = REQ_D;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and data requesters, one transaction
// at a time. Define MEM_ARB_RR_EN for round-robin tie breaking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                d_stall,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q;
    arb_state_e        state_d;
    req_id_e           grant_q;
    req_id_e           grant_pick;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

`ifdef MEM_ARB_RR_EN
    req_id_e           last_grant_q;
`endif

    arb_grant_sel u_grant_sel (
        .if_req     (if_req),
        .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .grant      (grant_pick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (if_req || d_req) state_d = ISSUE;
            ISSUE:   if (m_ready)         state_d = WAIT;
            WAIT:    if (m_rvalid)        state_d = RESP;
            RESP:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // The command is frozen at grant time so requester glitches cannot reach memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= REQ_IF;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (if_req || d_req)) begin
                grant_q <= grant_pick;
                if (grant_pick == REQ_D) begin
                    we_q    <= d_we;
                    be_q    <= d_be;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                end else begin
                    we_q    <= 1'b0;
                    be_q    <= '1;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                end
            end
            if (state_q == WAIT && m_rvalid) begin
                if (grant_q == REQ_D) begin
                    d_rdata_q <= m_rdata;
                end else begin
                    if_rdata_q <= m_rdata;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= REQ_IF;
        end else if (state_q == RESP) begin
            last_grant_q <= grant_q;
        end
    end
`endif

    assign m_valid  = (state_q == ISSUE);
    assign m_we     = we_q;
    assign m_be     = be_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_done  = (state_q == RESP) && (grant_q == REQ_IF);
    assign d_done   = (state_q == RESP) && (grant_q == REQ_D);
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

`ifndef SYNTHESIS
    // A response is only meaningful while a command is outstanding.
    rvalid_only_in_wait: assert property (@(posedge clk) disable iff (reset)
        m_rvalid |-> (state_q == WAIT));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions plus
// hand-written tie, back-to-back, and reset corner cases.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_d_rdata  = 32'h0;

    typedef struct {
        logic        is_d;
        mem_cmd_t    cmd_in;
        int          ready_wait;
        int          resp_wait;
        logic [31:0] resp_data;
        mem_cmd_t    exp_cmd;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[5];

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .d_stall  (d_stall),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    function automatic mem_cmd_t mk_cmd(input logic we, input logic [3:0] be,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        mem_cmd_t c;
        c.we    = we;
        c.be    = be;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

    function automatic vec_t mk_vec(input logic is_d, input mem_cmd_t cmd_in, input int rw,
                                    input int sw, input logic [31:0] rd,
                                    input mem_cmd_t exp_cmd, input int exp_cycles);
        vec_t v;
        v.is_d       = is_d;
        v.cmd_in     = cmd_in;
        v.ready_wait = rw;
        v.resp_wait  = sw;
        v.resp_data  = rd;
        v.exp_cmd    = exp_cmd;
        v.exp_cycles = exp_cycles;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic is_d, input mem_cmd_t c);
        if (is_d) begin
            d_req   = 1'b1;
            d_we    = c.we;
            d_be    = c.be;
            d_addr  = c.addr;
            d_wdata = c.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = c.addr;
        end
    endtask

    // Acts as the memory: accepts after ready_wait stalled ISSUE cycles and
    // responds resp_wait cycles after the first WAIT cycle.
    task automatic serveTxn(input string tag, input logic exp_is_d, input mem_cmd_t exp_cmd,
                            input int ready_wait, input int resp_wait,
                            input logic [31:0] resp_data, input int exp_cycles);
        int   cycles    = 0;
        int   issue_n   = 0;
        int   wait_n    = 0;
        logic accepted  = 1'b0;
        logic in_wait   = 1'b0;
        logic done_seen = 1'b0;
        while (!done_seen && cycles < 50) begin
            tick();
            cycles++;
            m_rvalid = 1'b0;
            if (accepted) begin
                accepted = 1'b0;
                in_wait  = 1'b1;
                m_ready  = 1'b0;
            end
            if (if_done || d_done) begin
                done_seen = 1'b1;
                if (exp_is_d) exp_d_rdata = resp_data;
                else          exp_if_rdata = resp_data;
                checkOutput({tag, "/done_cycle"}, 32'(cycles), 32'(exp_cycles));
                checkOutput({tag, "/d_done"}, 32'(d_done), 32'(exp_is_d));
                checkOutput({tag, "/if_done"}, 32'(if_done), 32'(!exp_is_d));
                checkOutput({tag, "/if_rdata"}, if_rdata, exp_if_rdata);
                checkOutput({tag, "/d_rdata"}, d_rdata, exp_d_rdata);
                checkOutput({tag, "/if_stall_done"}, 32'(if_stall), 32'(if_req && exp_is_d));
                checkOutput({tag, "/d_stall_done"}, 32'(d_stall), 32'(d_req && !exp_is_d));
            end else begin
                checkOutput({tag, "/if_stall"}, 32'(if_stall), 32'(if_req));
                checkOutput({tag, "/d_stall"}, 32'(d_stall), 32'(d_req));
                if (m_valid) begin
                    issue_n++;
                    checkOutput({tag, "/m_we"}, 32'(m_we), 32'(exp_cmd.we));
                    checkOutput({tag, "/m_be"}, 32'(m_be), 32'(exp_cmd.be));
                    checkOutput({tag, "/m_addr"}, m_addr, exp_cmd.addr);
                    checkOutput({tag, "/m_wdata"}, m_wdata, exp_cmd.wdata);
                    m_ready  = (issue_n > ready_wait);
                    accepted = m_ready;
                end else if (in_wait) begin
                    wait_n++;
                    if (wait_n > resp_wait) begin
                        m_rvalid = 1'b1;
                        m_rdata  = resp_data;
                        in_wait  = 1'b0;
                    end
                end
            end
        end
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        if (!done_seen) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s/timeout: no done within 50 cycles, expected one at cycle %0d",
                     tag, exp_cycles);
        end
    endtask

    // The cycle after RESP: no lingering done and no re-grant of a dropped request.
    task automatic finishTxn(input string tag, input logic drop_if, input logic drop_d);
        if (drop_if) if_req = 1'b0;
        if (drop_d)  d_req  = 1'b0;
        tick();
        checkOutput({tag, "/if_done_after"}, 32'(if_done), 32'h0);
        checkOutput({tag, "/d_done_after"}, 32'(d_done), 32'h0);
        checkOutput({tag, "/m_valid_after"}, 32'(m_valid), 32'h0);
    endtask

    initial begin
        logic     rr_exp_d;
        mem_cmd_t d_cmd;
        mem_cmd_t if_cmd;

        vecs[0] = mk_vec(1'b0, mk_cmd(1'b0, 4'h0, 32'h0000_0100, 32'h0), 0, 0, 32'h0050_0093,
                         mk_cmd(1'b0, 4'hF, 32'h0000_0100, 32'h0), 3);
        vecs[1] = mk_vec(1'b1, mk_cmd(1'b1, 4'b0011, 32'h0000_2004, 32'hDEAD_BEEF), 3, 0, 32'h0,
                         mk_cmd(1'b1, 4'b0011, 32'h0000_2004, 32'hDEAD_BEEF), 6);
        vecs[2] = mk_vec(1'b1, mk_cmd(1'b0, 4'hF, 32'h0000_2008, 32'h0), 0, 2, 32'hCAFE_F00D,
                         mk_cmd(1'b0, 4'hF, 32'h0000_2008, 32'h0), 5);
        vecs[3] = mk_vec(1'b0, mk_cmd(1'b0, 4'h0, 32'h0000_0104, 32'h0), 1, 1, 32'h0010_8093,
                         mk_cmd(1'b0, 4'hF, 32'h0000_0104, 32'h0), 5);
        vecs[4] = mk_vec(1'b1, mk_cmd(1'b1, 4'b1000, 32'h0000_0003, 32'h1122_3344), 0, 0, 32'hFFFF_FFFF,
                         mk_cmd(1'b1, 4'b1000, 32'h0000_0003, 32'h1122_3344), 3);

        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_be     = 4'h0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        tick();
        tick();
        checkOutput("reset/m_valid", 32'(m_valid), 32'h0);
        checkOutput("reset/m_we", 32'(m_we), 32'h0);
        checkOutput("reset/m_be", 32'(m_be), 32'h0);
        checkOutput("reset/m_addr", m_addr, 32'h0);
        checkOutput("reset/m_wdata", m_wdata, 32'h0);
        checkOutput("reset/if_done", 32'(if_done), 32'h0);
        checkOutput("reset/d_done", 32'(d_done), 32'h0);
        checkOutput("reset/if_rdata", if_rdata, 32'h0);
        checkOutput("reset/d_rdata", d_rdata, 32'h0);
        reset = 1'b0;
        tick();

        // Tie straight out of reset: data wins in both arbitration modes.
        d_cmd  = mk_cmd(1'b0, 4'hF, 32'h0000_3000, 32'h0000_0055);
        if_cmd = mk_cmd(1'b0, 4'hF, 32'h0000_0108, 32'h0);
        applyStimulus(1'b1, d_cmd);
        applyStimulus(1'b0, if_cmd);
        serveTxn("tie/d", 1'b1, d_cmd, 0, 0, 32'hA5A5_0001, 3);
        finishTxn("tie/d", 1'b0, 1'b1);
        serveTxn("tie/if", 1'b0, if_cmd, 0, 0, 32'h0000_0013, 3);
        finishTxn("tie/if", 1'b1, 1'b0);

        // Both requesters held continuously across four transactions.
        d_cmd  = mk_cmd(1'b0, 4'hF, 32'h0000_3100, 32'h0);
        if_cmd = mk_cmd(1'b0, 4'hF, 32'h0000_0200, 32'h0);
        applyStimulus(1'b1, d_cmd);
        applyStimulus(1'b0, if_cmd);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            rr_exp_d = (k % 2 == 0);
`else
            rr_exp_d = 1'b1;
`endif
            serveTxn($sformatf("b2b%0d", k), rr_exp_d, rr_exp_d ? d_cmd : if_cmd,
                     0, 0, 32'hB000_0000 + 32'(k), 3);
            finishTxn($sformatf("b2b%0d", k), k == 3, k == 3);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].is_d, vecs[i].cmd_in);
            serveTxn($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].exp_cmd, vecs[i].ready_wait,
                     vecs[i].resp_wait, vecs[i].resp_data, vecs[i].exp_cycles);
            finishTxn($sformatf("vec%0d", i), !vecs[i].is_d, vecs[i].is_d);
        end

        // Reset lands in WAIT together with the response; the response must be dropped.
        applyStimulus(1'b1, mk_cmd(1'b0, 4'hF, 32'h0000_4000, 32'h0));
        tick();
        checkOutput("rst_mid/issue_valid", 32'(m_valid), 32'h1);
        m_ready = 1'b1;
        tick();
        m_ready  = 1'b0;
        reset    = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h1234_5678;
        tick();
        checkOutput("rst_mid/m_valid", 32'(m_valid), 32'h0);
        checkOutput("rst_mid/d_done", 32'(d_done), 32'h0);
        checkOutput("rst_mid/d_rdata", d_rdata, 32'h0);
        checkOutput("rst_mid/m_addr", m_addr, 32'h0);
        reset        = 1'b0;
        d_req        = 1'b0;
        m_rvalid     = 1'b0;
        exp_d_rdata  = 32'h0;
        exp_if_rdata = 32'h0;
        tick();
        checkOutput("rst_mid/d_done_next", 32'(d_done), 32'h0);
        checkOutput("rst_mid/m_valid_next", 32'(m_valid), 32'h0);

        if_cmd = mk_cmd(1'b0, 4'hF, 32'h0000_0300, 32'h0);
        applyStimulus(1'b0, if_cmd);
        serveTxn("post_rst", 1'b0, if_cmd, 0, 0, 32'h0000_0073, 3);
        finishTxn("post_rst", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
